// File: rtl/fwd_hazard_ctrl_if.sv
// Signal bundle between the pipeline core and the forwarding/hazard control block.
// The core drives decode and branch info; the control block returns mux selects, stall, flush and counters.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  ex_branch_taken;
  logic [1:0]            forward_a;
  logic [1:0]            forward_b;
  logic                  stall;
  logic                  flush;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, ex_branch_taken,
    input  forward_a, forward_b, stall, flush, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, ex_branch_taken,
    output forward_a, forward_b, stall, flush, stall_count, flush_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard control for a 5-stage pipeline: operand forwarding selects,
// load-use stall, taken-branch flush, and stall/flush event counters.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input logic               clk,
  input logic               reset,
  fwd_hazard_ctrl_if.slave  io_bus
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } stage_t;

  stage_t           r_ex, r_mem, r_wb;
  stage_t           w_id;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_flush, w_stall;
  logic [1:0]       w_fwd_a, w_fwd_b;

  // Nearest producer (EX/MEM) wins over MEM/WB; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                         input stage_t mem, input stage_t wb);
    if (mem.valid && mem.regwrite && (mem.rd != '0) && (mem.rd == src)) begin
      return 2'b10;
    end else if (wb.valid && wb.regwrite && (wb.rd != '0) && (wb.rd == src)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  always_comb begin
    w_id          = '0;
    w_flush       = io_bus.ex_branch_taken;
    w_stall       = 1'b0;
    w_fwd_a       = fwd_sel(r_ex.rs1, r_mem, r_wb);
    w_fwd_b       = fwd_sel(r_ex.rs2, r_mem, r_wb);
    if (io_bus.id_valid) begin
      w_id.valid    = 1'b1;
      w_id.rs1      = io_bus.id_rs1;
      w_id.rs2      = io_bus.id_rs2;
      w_id.rd       = io_bus.id_rd;
      w_id.regwrite = io_bus.id_regwrite;
      w_id.memread  = io_bus.id_memread;
    end
    // Both rs fields are compared even if rs2 is unused: a spurious stall is harmless.
    if (r_ex.valid && r_ex.memread && (r_ex.rd != '0) && io_bus.id_valid &&
        ((r_ex.rd == io_bus.id_rs1) || (r_ex.rd == io_bus.id_rs2)) && !w_flush) begin
      w_stall = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= (w_stall || w_flush) ? '0 : w_id;
      if (w_stall) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign io_bus.forward_a   = w_fwd_a;
  assign io_bus.forward_b   = w_fwd_b;
  assign io_bus.stall       = w_stall;
  assign io_bus.flush       = w_flush;
  assign io_bus.stall_count = r_stall_cnt;
  assign io_bus.flush_count = r_flush_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a negedge monitor pops and compares.
module tb_fwd_hazard_ctrl;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 32;

  logic clk;
  logic reset;

  fwd_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  fwd_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
  } ins_t;

  typedef struct packed {
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          st;
    logic          fl;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  // Reference pipeline: index 0 = instruction in EX, 1 = MEM, 2 = WB.
  ins_t          m_pipe [3];
  logic [CW-1:0] m_stalls;
  logic [CW-1:0] m_flushes;
  exp_t          exp_q [$];
  int            checks;
  int            failures;
  bit            last_stall;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Which older stage, if any, most recently produced register src.
  function automatic logic [1:0] ref_fwd(input logic [RW-1:0] src);
    for (int age = 1; age <= 2; age++) begin
      if (m_pipe[age].v && m_pipe[age].rw && m_pipe[age].rd != 0 && m_pipe[age].rd == src)
        return (age == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic issue(input ins_t id, input bit br, input bit rst, input bit chk);
    exp_t e;
    bit   ld_use;
    bus.id_valid        = id.v;
    bus.id_rs1          = id.rs1;
    bus.id_rs2          = id.rs2;
    bus.id_rd           = id.rd;
    bus.id_regwrite     = id.rw;
    bus.id_memread      = id.mr;
    bus.ex_branch_taken = br;
    reset               = rst;
    ld_use = m_pipe[0].v && m_pipe[0].mr && m_pipe[0].rd != 0 && id.v &&
             (m_pipe[0].rd == id.rs1 || m_pipe[0].rd == id.rs2);
    e.fa = ref_fwd(m_pipe[0].rs1);
    e.fb = ref_fwd(m_pipe[0].rs2);
    e.fl = br;
    e.st = ld_use && !br;
    e.sc = m_stalls;
    e.fc = m_flushes;
    last_stall = e.st;
    if (chk) exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      foreach (m_pipe[i]) m_pipe[i] = '0;
      m_stalls  = '0;
      m_flushes = '0;
    end else begin
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = (e.st || e.fl || !id.v) ? '0 : id;
      m_stalls  = m_stalls + (e.st ? 1 : 0);
      m_flushes = m_flushes + (e.fl ? 1 : 0);
    end
    #1;
  endtask

  function automatic ins_t mk(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                              input logic [RW-1:0] rd, input bit rw, input bit mr);
    ins_t r;
    r.v = 1'b1; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.rw = rw; r.mr = mr;
    return r;
  endfunction

  // Monitor: outputs are combinational every cycle, so compare each pending expectation mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("forward_a",   {30'd0, bus.forward_a}, {30'd0, e.fa});
        check("forward_b",   {30'd0, bus.forward_b}, {30'd0, e.fb});
        check("stall",       {31'd0, bus.stall},     {31'd0, e.st});
        check("flush",       {31'd0, bus.flush},     {31'd0, e.fl});
        check("stall_count", bus.stall_count, e.sc);
        check("flush_count", bus.flush_count, e.fc);
      end
    end
  end

  initial begin
    ins_t nop;
    ins_t cur;
    nop = '0;
    checks = 0;
    failures = 0;
    m_stalls = '0;
    m_flushes = '0;
    foreach (m_pipe[i]) m_pipe[i] = '0;
    #1;
    issue(nop, 0, 1, 0);
    issue(nop, 0, 1, 1);
    // Back-to-back ALU dependency on x5.
    issue(mk(5'd1, 5'd2, 5'd5, 1, 0), 0, 0, 1);
    issue(mk(5'd5, 5'd3, 5'd10, 1, 0), 0, 0, 1);
    repeat (3) issue(nop, 0, 0, 1);
    // x6 producer, unrelated, consumer on rs2.
    issue(mk(5'd1, 5'd2, 5'd6, 1, 0), 0, 0, 1);
    issue(mk(5'd1, 5'd2, 5'd11, 1, 0), 0, 0, 1);
    issue(mk(5'd4, 5'd6, 5'd12, 1, 0), 0, 0, 1);
    repeat (3) issue(nop, 0, 0, 1);
    // Two writers of x7, nearest wins.
    issue(mk(5'd1, 5'd2, 5'd7, 1, 0), 0, 0, 1);
    issue(mk(5'd3, 5'd4, 5'd7, 1, 0), 0, 0, 1);
    issue(mk(5'd7, 5'd7, 5'd13, 1, 0), 0, 0, 1);
    repeat (3) issue(nop, 0, 0, 1);
    // Load-use on x8: add is held one cycle then re-presented.
    issue(mk(5'd2, 5'd0, 5'd8, 1, 1), 0, 0, 1);
    issue(mk(5'd8, 5'd9, 5'd14, 1, 0), 0, 0, 1);
    issue(mk(5'd8, 5'd9, 5'd14, 1, 0), 0, 0, 1);
    repeat (3) issue(nop, 0, 0, 1);
    // x0 producers never forward or stall.
    issue(mk(5'd1, 5'd2, 5'd0, 1, 0), 0, 0, 1);
    issue(mk(5'd0, 5'd0, 5'd15, 1, 0), 0, 0, 1);
    issue(mk(5'd2, 5'd0, 5'd0, 1, 1), 0, 0, 1);
    issue(mk(5'd0, 5'd0, 5'd16, 1, 0), 0, 0, 1);
    repeat (3) issue(nop, 0, 0, 1);
    // Load-use coinciding with a taken branch: flush wins.
    issue(mk(5'd2, 5'd0, 5'd12, 1, 1), 0, 0, 1);
    issue(mk(5'd12, 5'd3, 5'd17, 1, 0), 1, 0, 1);
    repeat (3) issue(nop, 0, 0, 1);
    // Reset asserted during a stall cycle.
    issue(mk(5'd2, 5'd0, 5'd13, 1, 1), 0, 0, 1);
    issue(mk(5'd13, 5'd3, 5'd18, 1, 0), 0, 1, 1);
    issue(mk(5'd13, 5'd3, 5'd18, 1, 0), 0, 0, 1);
    repeat (2) issue(nop, 0, 0, 1);
    // Random traffic over a small register set to provoke hazards.
    cur = nop;
    for (int n = 0; n < 600; n++) begin
      bit br;
      bit rst;
      if (!last_stall) begin
        cur.v   = ($urandom_range(7) != 0);
        cur.rs1 = RW'($urandom_range(3));
        cur.rs2 = RW'($urandom_range(3));
        cur.rd  = RW'($urandom_range(3));
        cur.rw  = ($urandom_range(3) != 0);
        cur.mr  = cur.rw && ($urandom_range(2) == 0);
      end
      br  = ($urandom_range(7) == 0);
      rst = ($urandom_range(63) == 0);
      issue(cur, br, rst, 1);
    end
    issue(nop, 0, 0, 0);
    @(negedge clk);
    check("queue_drained", CW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
